// File: rtl/pll_lock_sequencer_if.sv
// Signals between the PLL lock sequencer, the PLL and the downstream reset consumer.
// loss_cnt exists only when PLL_SEQ_LOSS_CNT_EN is defined.
interface pll_lock_sequencer_if;
  logic       pll_locked;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fail;
  logic [2:0] state;
`ifdef PLL_SEQ_LOSS_CNT_EN
  logic [7:0] loss_cnt;

  modport master (input pll_locked, output pll_rst, sys_rst, ready, fail, state, loss_cnt);
  modport slave  (output pll_locked, input pll_rst, sys_rst, ready, fail, state, loss_cnt);
`else
  modport master (input pll_locked, output pll_rst, sys_rst, ready, fail, state);
  modport slave  (output pll_locked, input pll_rst, sys_rst, ready, fail, state);
`endif
endinterface

// File: rtl/pll_lock_sequencer.sv
// PLL reset pulse, lock wait with retry, and stable-lock window before releasing sys_rst.
// Define PLL_SEQ_LOSS_CNT_EN to add the saturating lock-loss counter (bus.loss_cnt).
module pll_lock_sequencer #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_STABLE  = 64,
  parameter int LOCK_TIMEOUT = 27000,
  parameter int MAX_RETRIES  = 3,
  parameter int CNT_W        = 16
) (
  input  logic                 refclk,
  input  logic                 rst,
  pll_lock_sequencer_if.master bus
);
  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_DONE  = CNT_W'(LOCK_STABLE);
  localparam logic [2:0]       RETRY_LIMIT  = 3'(MAX_RETRIES);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       retry_reg, retry_next;
  logic [1:0]       sync_reg;
  logic             lock_s;
  logic             pll_rst_reg, pll_rst_next;
  logic             sys_rst_reg, sys_rst_next;
  logic             ready_reg, ready_next;
  logic             fail_reg, fail_next;

  always_ff @(posedge refclk) begin
    if (rst) sync_reg <= '0;
    else     sync_reg <= {sync_reg[0], bus.pll_locked};
  end
  assign lock_s = sync_reg[1];

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_reg   <= PLL_RST;
      cnt_reg     <= '0;
      retry_reg   <= '0;
      pll_rst_reg <= 1'b1;
      sys_rst_reg <= 1'b1;
      ready_reg   <= 1'b0;
      fail_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      retry_reg   <= retry_next;
      pll_rst_reg <= pll_rst_next;
      sys_rst_reg <= sys_rst_next;
      ready_reg   <= ready_next;
      fail_reg    <= fail_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + CNT_ONE;
    retry_next = retry_reg;
    case (state_reg)
      PLL_RST: begin
        if (cnt_reg == RST_LAST) state_next = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // A lock seen on the final timeout cycle takes priority over the retry.
        if (lock_s) begin
          state_next = STABLE;
        end else if (cnt_reg == TIMEOUT_LAST) begin
          retry_next = retry_reg + 2'd1;
          state_next = (({1'b0, retry_reg} + 3'd1) == RETRY_LIMIT) ? FAIL : PLL_RST;
        end
      end
      STABLE: begin
        if (!lock_s)                     state_next = WAIT_LOCK;
        else if (cnt_reg == STABLE_DONE) state_next = RUN;
      end
      RUN: begin
        cnt_next = cnt_reg;
        if (!lock_s) begin
          state_next = PLL_RST;
          retry_next = '0;
        end
      end
      FAIL: begin
        cnt_next = cnt_reg;
      end
      default: state_next = PLL_RST;
    endcase

    // STABLE starts at 1 because the entry cycle already saw lock.
    if (state_next != state_reg) cnt_next = (state_next == STABLE) ? CNT_ONE : '0;

    pll_rst_next = (state_next == PLL_RST) || (state_next == FAIL);
    sys_rst_next = (state_next != RUN);
    ready_next   = (state_next == RUN);
    fail_next    = (state_next == FAIL);
  end

  assign bus.state   = state_reg;
  assign bus.pll_rst = pll_rst_reg;
  assign bus.sys_rst = sys_rst_reg;
  assign bus.ready   = ready_reg;
  assign bus.fail    = fail_reg;

`ifdef PLL_SEQ_LOSS_CNT_EN
  logic [7:0] loss_cnt_reg;

  always_ff @(posedge refclk) begin
    if (rst) begin
      loss_cnt_reg <= '0;
    end else if ((state_reg == RUN) && (state_next == PLL_RST) && (loss_cnt_reg != 8'hFF)) begin
      loss_cnt_reg <= loss_cnt_reg + 8'd1;
    end
  end
  assign bus.loss_cnt = loss_cnt_reg;
`endif
endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed and random checks of pll_lock_sequencer against a timestamp-based model.
// Define PLL_SEQ_LOSS_CNT_EN to also check loss_cnt.
module tb_pll_lock_sequencer;
  localparam int RST_CYCLES   = 4;
  localparam int LOCK_STABLE  = 8;
  localparam int LOCK_TIMEOUT = 20;
  localparam int MAX_RETRIES  = 2;

  logic refclk;
  logic rst;
  pll_lock_sequencer_if bus();

  pll_lock_sequencer #(
    .RST_CYCLES(RST_CYCLES), .LOCK_STABLE(LOCK_STABLE), .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .MAX_RETRIES(MAX_RETRIES), .CNT_W(16)
  ) dut (
    .refclk(refclk),
    .rst(rst),
    .bus(bus)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  int n_checks = 0;
  int n_fail = 0;
  int edge_n = 0;
  int base = 0;

  // Model: phase (spec encoding), edge at which it was entered, retries, losses.
  int   m_phase = 0;
  int   m_entry = 0;
  int   m_retry = 0;
  int   m_loss = 0;
  logic lock_q[$];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s edge=%0d observed=%0d expected=%0d", tag, edge_n - base, obs, exp);
    end
  endtask

  task automatic enter(input int p);
    m_phase = p;
    m_entry = edge_n;
  endtask

  // lock as seen by the sequencer at an edge is pll_locked from two edges earlier.
  task automatic model_edge(input logic r, input logic lk);
    logic ls;
    if (r) begin
      enter(0);
      m_retry = 0;
      m_loss = 0;
      lock_q = '{1'b0, 1'b0};
      return;
    end
    ls = lock_q.pop_front();
    lock_q.push_back(lk);
    case (m_phase)
      0: if (edge_n - m_entry == RST_CYCLES) enter(1);
      1: begin
        if (ls) enter(2);
        else if (edge_n - m_entry == LOCK_TIMEOUT) begin
          m_retry++;
          if (m_retry == MAX_RETRIES) enter(4);
          else enter(0);
        end
      end
      2: begin
        if (!ls) enter(1);
        else if (edge_n - m_entry == LOCK_STABLE) enter(3);
      end
      3: begin
        if (!ls) begin
          enter(0);
          m_retry = 0;
          if (m_loss < 255) m_loss++;
        end
      end
      default: ;
    endcase
  endtask

  task automatic compare_all();
    chk("state", {5'b0, bus.state}, 8'(m_phase));
    chk("pll_rst", {7'b0, bus.pll_rst}, {7'b0, (m_phase == 0) || (m_phase == 4)});
    chk("sys_rst", {7'b0, bus.sys_rst}, {7'b0, m_phase != 3});
    chk("ready", {7'b0, bus.ready}, {7'b0, m_phase == 3});
    chk("fail_out", {7'b0, bus.fail}, {7'b0, m_phase == 4});
`ifdef PLL_SEQ_LOSS_CNT_EN
    chk("loss_cnt", bus.loss_cnt, 8'(m_loss));
`endif
  endtask

  task automatic tick(input logic r, input logic lk);
    rst = r;
    bus.pll_locked = lk;
    @(posedge refclk);
    edge_n++;
    model_edge(r, lk);
    #1;
    compare_all();
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_state"}, {5'b0, bus.state}, 8'd0);
    chk({tag, "_pll_rst"}, {7'b0, bus.pll_rst}, 8'd1);
    chk({tag, "_sys_rst"}, {7'b0, bus.sys_rst}, 8'd1);
    chk({tag, "_ready"}, {7'b0, bus.ready}, 8'd0);
    chk({tag, "_fail"}, {7'b0, bus.fail}, 8'd0);
`ifdef PLL_SEQ_LOSS_CNT_EN
    chk({tag, "_loss_cnt"}, bus.loss_cnt, 8'd0);
`endif
  endtask

  task automatic do_reset();
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    chk_reset_values("rst");
    base = edge_n;
  endtask

  initial begin
    int seg_left;
    logic lvl;
    rst = 1'b1;
    bus.pll_locked = 1'b0;

    // Normal bring-up: lock rises at edge 10.
    do_reset();
    for (int t = 1; t <= 24; t++) begin
      tick(1'b0, t >= 10);
      if (t == 3)  chk("bringup_pll_rst_e3", {7'b0, bus.pll_rst}, 8'd1);
      if (t == 4)  chk("bringup_state_e4", {5'b0, bus.state}, 8'd1);
      if (t == 4)  chk("bringup_pll_rst_e4", {7'b0, bus.pll_rst}, 8'd0);
      if (t == 19) chk("bringup_ready_e19", {7'b0, bus.ready}, 8'd0);
      if (t == 20) chk("bringup_ready_e20", {7'b0, bus.ready}, 8'd1);
      if (t == 20) chk("bringup_sys_rst_e20", {7'b0, bus.sys_rst}, 8'd0);
    end
    $display("step bringup: checks=%0d failures=%0d", n_checks, n_fail);

    // Lock loss in RUN (low sampled at edges 1,2), then reacquire.
    base = edge_n;
    for (int t = 1; t <= 24; t++) begin
      tick(1'b0, t >= 3);
      if (t == 2)  chk("loss_ready_e2", {7'b0, bus.ready}, 8'd1);
      if (t == 3)  chk("loss_ready_e3", {7'b0, bus.ready}, 8'd0);
      if (t == 3)  chk("loss_pll_rst_e3", {7'b0, bus.pll_rst}, 8'd1);
      if (t == 3)  chk("loss_sys_rst_e3", {7'b0, bus.sys_rst}, 8'd1);
`ifdef PLL_SEQ_LOSS_CNT_EN
      if (t == 3)  chk("loss_cnt_e3", bus.loss_cnt, 8'd1);
`endif
      if (t == 7)  chk("loss_state_e7", {5'b0, bus.state}, 8'd1);
      if (t == 16) chk("loss_ready_e16", {7'b0, bus.ready}, 8'd1);
    end
    $display("step lock_loss: checks=%0d failures=%0d", n_checks, n_fail);

    // Retry consumed, lock, loss, then one timeout must not reach the terminal state.
    do_reset();
    for (int t = 1; t <= 90; t++) begin
      tick(1'b0, (t >= 30 && t < 45) || t >= 72);
      if (t == 24) chk("retry_state_e24", {5'b0, bus.state}, 8'd0);
      if (t == 40) chk("retry_ready_e40", {7'b0, bus.ready}, 8'd1);
      if (t == 71) chk("retry_state_e71", {5'b0, bus.state}, 8'd0);
      if (t == 71) chk("retry_fail_e71", {7'b0, bus.fail}, 8'd0);
      if (t == 84) chk("retry_ready_e84", {7'b0, bus.ready}, 8'd1);
    end
    $display("step retry_clear: checks=%0d failures=%0d", n_checks, n_fail);

    // No lock: two attempts then terminal, even if lock later appears.
    do_reset();
    for (int t = 1; t <= 60; t++) begin
      tick(1'b0, t >= 49);
      if (t == 24) chk("timeout_state_e24", {5'b0, bus.state}, 8'd0);
      if (t == 28) chk("timeout_state_e28", {5'b0, bus.state}, 8'd1);
      if (t == 47) chk("timeout_state_e47", {5'b0, bus.state}, 8'd1);
      if (t == 48) chk("timeout_state_e48", {5'b0, bus.state}, 8'd4);
      if (t == 48) chk("timeout_fail_e48", {7'b0, bus.fail}, 8'd1);
      if (t == 60) chk("timeout_fail_e60", {7'b0, bus.fail}, 8'd1);
    end
    tick(1'b1, 1'b1);
    chk_reset_values("rst_in_term");
    $display("step timeout: checks=%0d failures=%0d", n_checks, n_fail);

    // Single-cycle dropout in STABLE restarts the window.
    do_reset();
    for (int t = 1; t <= 32; t++) begin
      tick(1'b0, t >= 10 && t != 17);
      if (t == 16) chk("dropout_state_e16", {5'b0, bus.state}, 8'd2);
      if (t == 19) chk("dropout_state_e19", {5'b0, bus.state}, 8'd1);
      if (t == 20) chk("dropout_state_e20", {5'b0, bus.state}, 8'd2);
      if (t == 27) chk("dropout_ready_e27", {7'b0, bus.ready}, 8'd0);
      if (t == 28) chk("dropout_ready_e28", {7'b0, bus.ready}, 8'd1);
    end
    $display("step dropout: checks=%0d failures=%0d", n_checks, n_fail);

    // Lock seen on the final timeout cycle wins and consumes no retry.
    do_reset();
    for (int t = 1; t <= 50; t++) begin
      tick(1'b0, t >= 22 && t <= 25);
      if (t == 23) chk("edge_lock_state_e23", {5'b0, bus.state}, 8'd1);
      if (t == 24) chk("edge_lock_state_e24", {5'b0, bus.state}, 8'd2);
      if (t == 28) chk("edge_lock_state_e28", {5'b0, bus.state}, 8'd1);
      if (t == 48) chk("edge_lock_state_e48", {5'b0, bus.state}, 8'd0);
    end
    $display("step edge_lock: checks=%0d failures=%0d", n_checks, n_fail);

    // Reset asserted mid-STABLE.
    do_reset();
    for (int t = 1; t <= 7; t++) begin
      tick(1'b0, 1'b1);
      if (t == 5) chk("mid_stable_state_e5", {5'b0, bus.state}, 8'd2);
    end
    tick(1'b1, 1'b1);
    chk_reset_values("rst_mid_stable");
    $display("step rst_mid_stable: checks=%0d failures=%0d", n_checks, n_fail);

    // Random lock waveforms with occasional resets.
    for (int r = 0; r < 3; r++) begin
      do_reset();
      seg_left = 0;
      lvl = 1'b0;
      for (int t = 0; t < 300; t++) begin
        if (seg_left == 0) begin
          lvl = 1'($urandom_range(0, 1));
          seg_left = $urandom_range(1, 30);
        end
        tick($urandom_range(0, 199) == 0, lvl);
        seg_left--;
      end
      $display("step random_%0d: checks=%0d failures=%0d", r, n_checks, n_fail);
    end

`ifdef PLL_SEQ_LOSS_CNT_EN
    // Repeated RUN losses saturate the loss counter.
    do_reset();
    for (int p = 0; p < 300; p++) begin
      for (int i = 0; i < 24; i++) tick(1'b0, 1'b1);
      tick(1'b0, 1'b0);
    end
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1);
    chk("loss_cnt_saturated", bus.loss_cnt, 8'd255);
    $display("step loss_saturate: checks=%0d failures=%0d", n_checks, n_fail);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
